crash_detect: RTL

Per-pixel collision arbiter for the play field, sitting directly upstream of the enemy1 layer and alongside the player and bullet layers. It compares the alpha outputs of the player plane, bullet and enemy1 layers on the same `clk_vga` pixel and drives `crash_enemy_bullet_o` and `crash_me_enemy_o` straight into the enemy1 crash inputs. It also owns the per-game life counter, the post-hit invincibility window, the score accumulator and the game-over state.

---
 rtl/crash_detect.sv | 125 ++++++++++++
 1 files changed

// File: rtl/crash_detect.sv
// Per-pixel collision arbiter for the play field: crash strobes to the enemy1 layer,
// plus lives, post-hit invincibility, score and game-over tracking.
module crash_detect #(
  parameter int LIVES             = 3,
  parameter int INVINCIBLE_FRAMES = 120,
  parameter int SCORE_WIDTH       = 16,
  parameter int ENEMY1_POINTS     = 1
) (
  input  logic                   clk_vga,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   v_sync_i,
  input  logic                   me_alpha_i,
  input  logic                   bullet_alpha_i,
  input  logic                   enemy1_alpha_i,
  output logic                   crash_enemy_bullet_o,
  output logic                   crash_me_enemy_o,
  output logic [2:0]             lives_o,
  output logic [SCORE_WIDTH-1:0] score_o,
  output logic                   me_visible_o,
  output logic                   game_over_o
);

  typedef enum logic [1:0] {PLAY, INVINCIBLE, GAME_OVER} state_t;

  localparam logic [7:0] INV_LAST   = 8'(INVINCIBLE_FRAMES - 1);
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  state_t                 r_state, w_state_nx;
  logic [2:0]             r_lives, w_lives_nx;
  logic [7:0]             r_inv_cnt, w_inv_cnt_nx;
  logic [7:0]             r_frame_cnt;
  logic                   r_hit_flag;
  logic                   r_vsync_d;
  logic [SCORE_WIDTH-1:0] r_score;
  logic                   w_frame_end;
  logic                   w_unused;

  function automatic logic [SCORE_WIDTH-1:0] sat_add(input logic [SCORE_WIDTH-1:0] a);
    logic [SCORE_WIDTH:0] sum;
    sum = {1'b0, a} + (SCORE_WIDTH+1)'(ENEMY1_POINTS);
    if (sum[SCORE_WIDTH]) return '1;
    return sum[SCORE_WIDTH-1:0];
  endfunction

  assign w_frame_end = r_vsync_d & ~v_sync_i;

  // Crash strobes stay combinational so the enemy1 index lookup sees the same pixel
  assign crash_enemy_bullet_o = en_i & bullet_alpha_i & enemy1_alpha_i & (r_state != GAME_OVER);
  assign crash_me_enemy_o     = en_i & me_alpha_i & enemy1_alpha_i & (r_state == PLAY);

  always_comb begin
    w_state_nx   = r_state;
    w_lives_nx   = r_lives;
    w_inv_cnt_nx = r_inv_cnt;
    case (r_state)
      PLAY: begin
        if (crash_me_enemy_o) begin
          if (r_lives > 3'd1) begin
            w_state_nx   = INVINCIBLE;
            w_lives_nx   = r_lives - 3'd1;
            w_inv_cnt_nx = 8'd0;
          end else begin
            w_state_nx = GAME_OVER;
            w_lives_nx = 3'd0;
          end
        end
      end
      INVINCIBLE: begin
        if (w_frame_end) begin
          if (r_inv_cnt == INV_LAST) begin
            w_state_nx   = PLAY;
            w_inv_cnt_nx = 8'd0;
          end else begin
            w_inv_cnt_nx = r_inv_cnt + 8'd1;
          end
        end
      end
      GAME_OVER: w_state_nx = GAME_OVER;
      default:   w_state_nx = PLAY;
    endcase
  end

  // The v_sync delay keeps tracking while disabled so re-enabling never fakes a frame end
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_state     <= PLAY;
      r_lives     <= LIVES_INIT;
      r_inv_cnt   <= 8'd0;
      r_frame_cnt <= 8'd0;
      r_hit_flag  <= 1'b0;
      r_score     <= '0;
      r_vsync_d   <= 1'b1;
    end else begin
      r_vsync_d <= v_sync_i;
      if (en_i) begin
        r_state   <= w_state_nx;
        r_lives   <= w_lives_nx;
        r_inv_cnt <= w_inv_cnt_nx;
        if (w_frame_end) begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
          if (r_hit_flag) r_score <= sat_add(r_score);
          r_hit_flag <= crash_enemy_bullet_o;
        end else if (crash_enemy_bullet_o) begin
          r_hit_flag <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    me_visible_o = 1'b0;
    case (r_state)
      PLAY:       me_visible_o = 1'b1;
      INVINCIBLE: me_visible_o = ~r_frame_cnt[3];
      default:    me_visible_o = 1'b0;
    endcase
  end

  assign lives_o     = r_lives;
  assign score_o     = r_score;
  assign game_over_o = (r_state == GAME_OVER);
  assign w_unused    = ^{r_frame_cnt[7:4], r_frame_cnt[2:0]};

endmodule
